// File: rtl/alu_issue_wb.sv
// Issue/writeback stage around the combinational ALU: it owns the register file and the
// architectural flags. A four-state sequencer retires one instruction every four cycles.
module alu_issue_wb #(
    parameter int DW   = 32,
    parameter int NREG = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [2:0]    in_op,
    input  logic          in_dir,
    input  logic [4:0]    in_rs,
    input  logic [4:0]    in_rt,
    input  logic [4:0]    in_rd,
    input  logic          in_use_imm,
    input  logic [DW-1:0] in_imm,
    input  logic          in_use_carry,
    input  logic          in_wb_en,
    output logic [DW-1:0] alu_reg1,
    output logic [DW-1:0] alu_reg2,
    output logic [2:0]    alu_op,
    output logic          alu_cin,
    output logic          alu_dir,
    input  logic [DW-1:0] alu_res,
    input  logic          alu_carry,
    input  logic          alu_zero,
    input  logic          alu_neg,
    input  logic          alu_ovf,
    input  logic          alu_update_carry,
    output logic [3:0]    flags,
    output logic          done,
    input  logic [4:0]    dbg_addr,
    output logic [DW-1:0] dbg_data
);
    typedef enum logic [1:0] {S_IDLE, S_OPR, S_EXE, S_WB} state_t;

    state_t        r_state, w_next;
    logic [DW-1:0] r_rf [NREG];
    logic [2:0]    r_op;
    logic          r_dir, r_use_imm, r_use_carry, r_wb_en;
    logic [4:0]    r_rs, r_rt, r_rd;
    logic [DW-1:0] r_imm, r_res, r_reg1, r_reg2;
    logic [2:0]    r_alu_op;
    logic          r_cin, r_alu_dir, r_done;
    logic [3:0]    r_flags;
    logic          w_accept;
    logic [DW-1:0] w_rs_data, w_rt_data;

    // R0 and any address beyond the implemented file read as zero.
    function automatic logic [DW-1:0] rf_rd(input logic [4:0] a, input logic [DW-1:0] v);
        return (a == 5'd0 || 32'(a) >= NREG) ? '0 : v;
    endfunction

    assign w_rs_data = rf_rd(r_rs, r_rf[r_rs]);
    assign w_rt_data = rf_rd(r_rt, r_rf[r_rt]);
    assign dbg_data  = rf_rd(dbg_addr, r_rf[dbg_addr]);

    assign in_ready = (r_state == S_IDLE);
    assign w_accept = in_valid && in_ready;
    assign alu_reg1 = r_reg1;
    assign alu_reg2 = r_reg2;
    assign alu_op   = r_alu_op;
    assign alu_cin  = r_cin;
    assign alu_dir  = r_alu_dir;
    assign flags    = r_flags;
    assign done     = r_done;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_next = S_OPR;
            S_OPR:   w_next = S_EXE;
            S_EXE:   w_next = S_WB;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op <= '0; r_dir <= 1'b0; r_rs <= '0; r_rt <= '0; r_rd <= '0;
            r_use_imm <= 1'b0; r_imm <= '0; r_use_carry <= 1'b0; r_wb_en <= 1'b0;
            r_reg1 <= '0; r_reg2 <= '0; r_alu_op <= '0; r_cin <= 1'b0; r_alu_dir <= 1'b0;
            r_res <= '0; r_flags <= '0; r_done <= 1'b0;
            for (int i = 0; i < NREG; i++) r_rf[i] <= '0;
        end else begin
            r_done <= (r_state == S_WB);
            case (r_state)
                S_IDLE: if (w_accept) begin
                    r_op <= in_op; r_dir <= in_dir;
                    r_rs <= in_rs; r_rt <= in_rt; r_rd <= in_rd;
                    r_use_imm <= in_use_imm; r_imm <= in_imm;
                    r_use_carry <= in_use_carry; r_wb_en <= in_wb_en;
                end
                S_OPR: begin
                    r_reg1    <= w_rs_data;
                    r_reg2    <= r_use_imm ? r_imm : w_rt_data;
                    r_alu_op  <= r_op;
                    r_alu_dir <= r_dir;
                    r_cin     <= r_use_carry & r_flags[3];
                end
                S_EXE: begin
                    r_res   <= alu_res;
                    // Carry is sticky across ops that do not define it.
                    r_flags <= {alu_update_carry ? alu_carry : r_flags[3], alu_zero, alu_neg, alu_ovf};
                end
                default: begin
                    if (r_wb_en && r_rd != 5'd0 && 32'(r_rd) < NREG) r_rf[r_rd] <= r_res;
                end
            endcase
        end
    end
endmodule
